// File: rtl/nmcu_instr_sched_pkg.sv
// Shared types for the NMCU instruction scheduler: the instruction word
// coming over the CPU link, the response word going back, and the constants
// both sides agree on.
package nmcu_instr_sched_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_MAC   = 4'h3,
    OP_HALT  = 4'h4
  } opcode_t;

  typedef struct packed {
    opcode_t                opcode;
    logic [ADDR_WIDTH-1:0]  addr_a;
    logic [ADDR_WIDTH-1:0]  addr_b;
    logic [ADDR_WIDTH-1:0]  addr_c;
    logic [DATA_WIDTH-1:0]  data;
    logic [LEN_WIDTH-1:0]   len;
  } instruction_t;

  typedef enum logic [1:0] {
    RESP_OK   = 2'd0,
    RESP_ERR  = 2'd1,
    RESP_BUSY = 2'd2
  } resp_status_t;

  typedef struct packed {
    logic                   valid;
    resp_status_t           status;
    logic [DATA_WIDTH-1:0]  data;
  } nmcu_cpu_resp_t;

  // Marker returned in the data field when a sub-unit never answered.
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_0001);

  // LOAD and STORE both go to the memory access unit.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/nmcu_sync_fifo.sv
// Single-clock FIFO with full/empty/count status. A push while full is
// accepted only when a pop happens in the same cycle. i_clr empties the
// FIFO in one cycle and takes priority over push and pop.
module nmcu_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/nmcu_instr_sched.sv
// NMCU instruction scheduler. Buffers CPU instructions, executes them one
// at a time in order (memory ops to the memory access unit, MAC to the MAC
// engine), supervises each sub-unit with a timeout and returns exactly one
// response per accepted instruction. After HALT it only answers BUSY.
module nmcu_instr_sched
  import nmcu_instr_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  instruction_t           instr,
  output nmcu_cpu_resp_t         resp,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  output logic [LEN_WIDTH-1:0]   mem_req_len,
  input  logic                   mem_done,
  input  logic                   mem_err,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   mem_abort,
  output logic                   mac_start,
  input  logic                   mac_ready,
  output logic [ADDR_WIDTH-1:0]  mac_addr_a,
  output logic [ADDR_WIDTH-1:0]  mac_addr_b,
  output logic [ADDR_WIDTH-1:0]  mac_addr_c,
  output logic [DATA_WIDTH-1:0]  mac_cfg,
  output logic [LEN_WIDTH-1:0]   mac_len,
  input  logic                   mac_done,
  input  logic                   mac_err,
  output logic                   mac_abort,
  output logic                   busy,
  output logic                   halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE_MEM,
    S_WAIT_MEM,
    S_ISSUE_MAC,
    S_WAIT_MAC,
    S_RESP,
    S_HALTED
  } sched_state_t;

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  instruction_t           r_cur;
  instruction_t           w_head;
  logic [TMO_W-1:0]       r_tmo;
  resp_status_t           r_status;
  resp_status_t           w_status_nxt;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [DATA_WIDTH-1:0]  w_data_nxt;
  logic                   r_busy_pend;
  logic                   w_full;
  logic                   w_empty;
  logic [CNT_W-1:0]       w_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_tmo_hit;
  logic                   w_tmo_clr;
  logic                   w_set_resp;
  logic                   w_mem_to;
  logic                   w_mac_to;

  // Once halted nothing is buffered: new words are answered BUSY directly.
  assign w_push    = instr_valid && instr_ready && (r_state != S_HALTED);
  assign w_flush   = (r_state == S_HALTED);
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // A handshake or done arriving on the last allowed cycle beats the timeout.
  assign w_mem_to = w_tmo_hit &&
                    (((r_state == S_ISSUE_MEM) && !mem_req_ready) ||
                     ((r_state == S_WAIT_MEM)  && !mem_done));
  assign w_mac_to = w_tmo_hit &&
                    (((r_state == S_ISSUE_MAC) && !mac_ready) ||
                     ((r_state == S_WAIT_MAC)  && !mac_done));

  nmcu_sync_fifo #(
    .DATA_W ($bits(instruction_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_instr_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_flush),
    .i_push  (w_push),
    .i_wdata (instr),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic, plus the response contents captured on entry to RESP.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_tmo_clr    = 1'b1;
    w_set_resp   = 1'b0;
    w_status_nxt = RESP_OK;
    w_data_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (r_cur.opcode)
          OP_NOP, OP_HALT: w_set_resp = 1'b1;
          OP_LOAD, OP_STORE: w_state_nxt = S_ISSUE_MEM;
          OP_MAC:          w_state_nxt = S_ISSUE_MAC;
          default: begin
            w_set_resp   = 1'b1;
            w_status_nxt = RESP_ERR;
          end
        endcase
      end
      S_ISSUE_MEM: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT_MEM;
        end else if (w_mem_to) begin
          w_set_resp   = 1'b1;
          w_status_nxt = RESP_ERR;
          w_data_nxt   = TIMEOUT_DATA;
        end else begin
          w_tmo_clr = 1'b0;
        end
      end
      S_WAIT_MEM: begin
        if (mem_done) begin
          w_set_resp = 1'b1;
          if (mem_err) begin
            w_status_nxt = RESP_ERR;
          end else if (r_cur.opcode == OP_LOAD) begin
            w_data_nxt = mem_rdata;
          end
        end else if (w_mem_to) begin
          w_set_resp   = 1'b1;
          w_status_nxt = RESP_ERR;
          w_data_nxt   = TIMEOUT_DATA;
        end else begin
          w_tmo_clr = 1'b0;
        end
      end
      S_ISSUE_MAC: begin
        if (mac_ready) begin
          w_state_nxt = S_WAIT_MAC;
        end else if (w_mac_to) begin
          w_set_resp   = 1'b1;
          w_status_nxt = RESP_ERR;
          w_data_nxt   = TIMEOUT_DATA;
        end else begin
          w_tmo_clr = 1'b0;
        end
      end
      S_WAIT_MAC: begin
        if (mac_done) begin
          w_set_resp = 1'b1;
          if (mac_err) w_status_nxt = RESP_ERR;
        end else if (w_mac_to) begin
          w_set_resp   = 1'b1;
          w_status_nxt = RESP_ERR;
          w_data_nxt   = TIMEOUT_DATA;
        end else begin
          w_tmo_clr = 1'b0;
        end
      end
      S_RESP: begin
        w_state_nxt = (r_cur.opcode == OP_HALT) ? S_HALTED : S_IDLE;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_set_resp) w_state_nxt = S_RESP;
  end

  // Timeout counter and the pending BUSY answer while halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo       <= '0;
      r_busy_pend <= 1'b0;
    end else begin
      r_tmo       <= w_tmo_clr ? '0 : r_tmo + TMO_W'(1);
      r_busy_pend <= (r_state == S_HALTED) && instr_valid;
    end
  end

  // Current instruction and response payload; only read in states that own them.
  always_ff @(posedge clk) begin
    if (w_pop) r_cur <= w_head;
    if (w_set_resp) begin
      r_status <= w_status_nxt;
      r_data   <= w_data_nxt;
    end
  end

  // Outputs decoded from the current state; request fields are zero outside ISSUE.
  always_comb begin
    instr_ready   = (r_state == S_HALTED) ? 1'b1 : !w_full;
    resp          = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_len   = '0;
    mac_start     = 1'b0;
    mac_addr_a    = '0;
    mac_addr_b    = '0;
    mac_addr_c    = '0;
    mac_cfg       = '0;
    mac_len       = '0;
    case (r_state)
      S_ISSUE_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_write = (r_cur.opcode == OP_STORE);
        mem_req_addr  = r_cur.addr_a;
        mem_req_wdata = r_cur.data;
        mem_req_len   = r_cur.len;
      end
      S_ISSUE_MAC: begin
        mac_start  = 1'b1;
        mac_addr_a = r_cur.addr_a;
        mac_addr_b = r_cur.addr_b;
        mac_addr_c = r_cur.addr_c;
        mac_cfg    = r_cur.data;
        mac_len    = r_cur.len;
      end
      S_RESP: begin
        if (!rst) begin
          resp.valid  = 1'b1;
          resp.status = r_status;
          resp.data   = r_data;
        end
      end
      S_HALTED: begin
        if (!rst && r_busy_pend) begin
          resp.valid  = 1'b1;
          resp.status = RESP_BUSY;
        end
      end
      default: ;
    endcase
    // A reset mid-operation resets the sub-units too, so no abort is sent.
    mem_abort = w_mem_to && !rst;
    mac_abort = w_mac_to && !rst;
    busy      = (r_state != S_IDLE) || (w_count != '0);
    halted    = (r_state == S_HALTED);
  end

endmodule

// File: tb/tb_nmcu_instr_sched.sv
// Scoreboard bench for nmcu_instr_sched: expected responses are queued as
// instructions are driven and compared in order as responses appear. A
// behavioural memory unit checks request fields; the MAC engine never finishes.
module tb_nmcu_instr_sched;
  import nmcu_instr_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] l;
  } mreq_t;

  logic                  clk;
  logic                  rst;
  logic                  instr_valid;
  logic                  instr_ready;
  instruction_t          instr;
  nmcu_cpu_resp_t        resp;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [LEN_WIDTH-1:0]  mem_req_len;
  logic                  mem_done;
  logic                  mem_err;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_abort;
  logic                  mac_start;
  logic                  mac_ready;
  logic [ADDR_WIDTH-1:0] mac_addr_a;
  logic [ADDR_WIDTH-1:0] mac_addr_b;
  logic [ADDR_WIDTH-1:0] mac_addr_c;
  logic [DATA_WIDTH-1:0] mac_cfg;
  logic [LEN_WIDTH-1:0]  mac_len;
  logic                  mac_done;
  logic                  mac_err;
  logic                  mac_abort;
  logic                  busy;
  logic                  halted;

  int    n_asrt = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_resp_cyc = 0;
  int    done_cyc = 0;
  int    mem_valid_cycles = 0;
  int    mem_aborts = 0;
  int    mac_aborts = 0;
  int    mac_starts = 0;
  logic [31:0] mac_a_seen, mac_c_seen, mac_cfg_seen;
  int    mem_rdy_dly = 0;
  int    mem_done_dly = 1;
  logic [31:0] mem_rd_val = '0;
  exp_t  sb[$];
  mreq_t mem_exp_q[$];

  nmcu_instr_sched #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .resp          (resp),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_len   (mem_req_len),
    .mem_done      (mem_done),
    .mem_err       (mem_err),
    .mem_rdata     (mem_rdata),
    .mem_abort     (mem_abort),
    .mac_start     (mac_start),
    .mac_ready     (mac_ready),
    .mac_addr_a    (mac_addr_a),
    .mac_addr_b    (mac_addr_b),
    .mac_addr_c    (mac_addr_c),
    .mac_cfg       (mac_cfg),
    .mac_len       (mac_len),
    .mac_done      (mac_done),
    .mac_err       (mac_err),
    .mac_abort     (mac_abort),
    .busy          (busy),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that transferred.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d, input logic [15:0] l,
                      input bit exp_en, input logic [1:0] st, input logic [31:0] ed);
    instruction_t t;
    int n;
    t.opcode = opcode_t'(op);
    t.addr_a = a;
    t.addr_b = b;
    t.addr_c = c;
    t.data   = d;
    t.len    = l;
    instr       = t;
    instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", instr_ready, 1'b1);
    if (exp_en) sb.push_back('{st, ed});
    sync();
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic wait_drain(input bit need_idle);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || (need_idle && busy)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", sb.size(), 0);
    sync();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, {instr_ready, busy, halted, resp.valid, mac_start, mac_abort,
                        mem_req_valid, mem_abort, mem_req_write}, 9'b1_0000_0000);
    chk({tag, "_resp"}, {resp.status, resp.data}, 64'd0);
    chk({tag, "_mem"}, {mem_req_addr, mem_req_wdata}, 64'd0);
    chk({tag, "_mac"}, {mac_addr_a, mac_addr_b}, 64'd0);
    chk({tag, "_mac2"}, {mac_addr_c, mac_cfg}, 64'd0);
    chk({tag, "_len"}, {mac_len, mem_req_len}, 64'd0);
  endtask

  // Response scoreboard and sub-unit activity monitor.
  always @(negedge clk) begin
    if (mem_req_valid) mem_valid_cycles++;
    if (mem_abort) mem_aborts++;
    if (mac_abort) mac_aborts++;
    if (mac_start) begin
      mac_starts++;
      mac_a_seen   = mac_addr_a;
      mac_c_seen   = mac_addr_c;
      mac_cfg_seen = mac_cfg;
    end
    if (resp.valid) begin
      exp_t e;
      last_resp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("resp_unexpected", resp.valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("resp_status", resp.status, e.st);
        chk("resp_data", resp.data, e.d);
      end
    end
  end

  // Behavioural memory access unit.
  initial begin
    mreq_t cap;
    mreq_t ex;
    mem_req_ready = 1'b0;
    mem_done      = 1'b0;
    mem_err       = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !rst) begin
        cap.w = mem_req_write;
        cap.a = mem_req_addr;
        cap.d = mem_req_wdata;
        cap.l = mem_req_len;
        if (mem_exp_q.size() == 0) begin
          chk("mem_req_unexpected", mem_req_valid, 1'b0);
        end else begin
          ex = mem_exp_q.pop_front();
          chk("mem_req_wr_addr", {cap.w, cap.a}, {ex.w, ex.a});
          chk("mem_req_wdata_len", {cap.d, cap.l}, {ex.d, ex.l});
        end
        for (int i = 0; i < mem_rdy_dly; i++) begin
          @(negedge clk);
          chk("mem_req_hold", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_len},
              {1'b1, cap.w, cap.a, cap.l});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (mem_done_dly - 1) @(negedge clk);
        mem_done  = 1'b1;
        mem_rdata = mem_rd_val;
        done_cyc  = cyc;
        @(negedge clk);
        mem_done  = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    int ab0;
    int mv;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    mac_ready   = 1'b1;
    mac_done    = 1'b0;
    mac_err     = 1'b0;

    // Reset values, then a NOP with exact latency.
    repeat (3) sync();
    @(negedge clk);
    check_reset_vals("reset");
    sync();
    rst = 1'b0;
    c0 = cyc;
    send(OP_NOP, 0, 0, 0, 0, 0, 1'b1, RESP_OK, 32'h0);
    repeat (3) @(negedge clk);
    chk("nop_resp_valid_c3", resp.valid, 1'b1);
    chk("nop_busy_c3", busy, 1'b1);
    chk("nop_ready_c3", instr_ready, 1'b1);
    @(negedge clk);
    chk("nop_busy_c4", busy, 1'b0);
    chk("nop_ready_c4", instr_ready, 1'b1);
    chk("nop_latency", last_resp_cyc - c0, 3);
    sync();

    // LOAD with a slow handshake and a late done.
    mem_rdy_dly  = 5;
    mem_done_dly = 3;
    mem_rd_val   = 32'h0000_CAFE;
    mem_exp_q.push_back('{1'b0, 32'h100, 32'h5555, 16'd4});
    send(OP_LOAD, 32'h100, 0, 0, 32'h5555, 16'd4, 1'b1, RESP_OK, 32'h0000_CAFE);
    wait_drain(1'b1);
    chk("load_latency", last_resp_cyc, done_cyc + 1);

    // Five back-to-back STOREs into a stalled memory unit.
    mem_rdy_dly  = 10;
    mem_done_dly = 1;
    mem_rd_val   = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++)
      mem_exp_q.push_back('{1'b1, 32'h200 + 32'(i), 32'h1000 + 32'(i), 16'd1});
    for (int i = 0; i < 5; i++)
      send(OP_STORE, 32'h200 + 32'(i), 0, 0, 32'h1000 + 32'(i), 16'd1, 1'b1, RESP_OK, 32'h0);
    @(negedge clk);
    chk("store_fifo_full_ready", instr_ready, 1'b0);
    sync();
    wait_drain(1'b1);
    chk("store_mem_exp_empty", mem_exp_q.size(), 0);

    // MAC that never completes, followed by a NOP.
    ab0 = mac_aborts;
    send(OP_MAC, 32'h300, 32'h400, 32'h500, 32'h0004_0404, 16'd8, 1'b1, RESP_ERR, 32'hDEAD_0001);
    send(OP_NOP, 0, 0, 0, 0, 0, 1'b1, RESP_OK, 32'h0);
    wait_drain(1'b1);
    chk("mac_abort_pulses", mac_aborts - ab0, 1);
    chk("mac_fields", {mac_a_seen, mac_c_seen}, {32'h300, 32'h500});
    chk("mac_cfg", mac_cfg_seen, 32'h0004_0404);

    // Illegal opcode, HALT, then a LOAD once halted.
    send(4'h7, 0, 0, 0, 0, 0, 1'b1, RESP_ERR, 32'h0);
    send(OP_HALT, 0, 0, 0, 0, 0, 1'b1, RESP_OK, 32'h0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!halted && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("halted", halted, 1'b1);
    chk("halted_ready", instr_ready, 1'b1);
    mv = mem_valid_cycles;
    sync();
    send(OP_LOAD, 32'h600, 0, 0, 0, 16'd2, 1'b1, RESP_BUSY, 32'h0);
    wait_drain(1'b0);
    repeat (3) @(negedge clk);
    chk("halted_no_mem_req", mem_valid_cycles - mv, 0);
    chk("still_halted", halted, 1'b1);

    // Reset during WAIT_MAC with two instructions queued.
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    ab0 = mac_aborts;
    send(OP_MAC, 32'h700, 32'h800, 32'h900, 32'h1, 16'd1, 1'b0, RESP_OK, 32'h0);
    send(OP_NOP, 0, 0, 0, 0, 0, 1'b0, RESP_OK, 32'h0);
    send(OP_NOP, 0, 0, 0, 0, 0, 1'b0, RESP_OK, 32'h0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!mac_start && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("mac_start_seen", mac_start, 1'b1);
    end
    @(negedge clk);
    chk("wait_mac_busy", busy, 1'b1);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_quiet", {resp.valid, mac_abort, mem_abort}, 3'b000);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (6) @(negedge clk);
    chk("midrst_fifo_empty", busy, 1'b0);
    chk("midrst_no_abort", mac_aborts - ab0, 0);

    chk("sb_empty", sb.size(), 0);
    chk("no_mem_abort", mem_aborts, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/nmcu_instr_sched.md
Name: nmcu_instr_sched

Overview:
Instruction scheduler and controller between the chiplet CPU link and the NMCU datapath. Accepts instruction_t words through a valid/ready handshake and buffers them in a small FIFO. Executes them strictly in order: it dispatches LOAD and STORE to the memory access unit and MAC to the MAC engine. Returns one nmcu_cpu_resp_t per accepted instruction, with timeout, error and halt handling.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for a sub-unit's done before the instruction is aborted.
ADDR_WIDTH, DATA_WIDTH, LEN_WIDTH: taken from nmcu_pkg, not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset
instr_valid  in  1  CPU instruction valid
instr_ready  out  1  scheduler can accept an instruction
instr  in  $bits(instruction_t)  instruction
resp  out  $bits(nmcu_cpu_resp_t)  response; resp.valid is a one-cycle pulse
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory unit accepts request
mem_req_write  out  1  1 = STORE, 0 = LOAD
mem_req_addr  out  ADDR_WIDTH  address (addr_a)
mem_req_wdata  out  DATA_WIDTH  store value (instr.data)
mem_req_len  out  LEN_WIDTH  length
mem_done  in  1  memory operation complete (1-cycle pulse)
mem_err  in  1  qualifies mem_done
mem_rdata  in  DATA_WIDTH  load result, valid with mem_done
mem_abort  out  1  1-cycle abort pulse
mac_start  out  1  MAC start request
mac_ready  in  1  MAC accepts start
mac_addr_a, mac_addr_b, mac_addr_c  out  ADDR_WIDTH  operand and result bases
mac_cfg  out  DATA_WIDTH  instr.data (M,N,K packing)
mac_len  out  LEN_WIDTH  instr.len
mac_done  in  1  MAC complete (1-cycle pulse)
mac_err  in  1  qualifies mac_done
mac_abort  out  1  1-cycle abort pulse
busy  out  1  FSM not in IDLE, or FIFO not empty
halted  out  1  FSM in HALTED

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high; it overrides all other inputs.
- Reset values: all outputs 0 except instr_ready = 1. FIFO is emptied, FSM enters IDLE, timeout counter is 0.
- Reset asserted mid-operation: abort pulses are NOT generated; sub-units are reset by the same rst.
- instr_ready = !fifo_full in every state except HALTED, where it is 1. Transfer occurs on instr_valid && instr_ready.
- Push and pop in the same cycle while the FIFO is full is allowed, and instr_ready stays 0 that cycle.
- FSM states: IDLE, DECODE, ISSUE_MEM, WAIT_MEM, ISSUE_MAC, WAIT_MAC, RESP, HALTED.
- IDLE: if the FIFO is non-empty, pop the head into the current-instruction register and go to DECODE.
- DECODE, by opcode:
  - NOP -> RESP with status OK.
  - LOAD or STORE -> ISSUE_MEM.
  - MAC -> ISSUE_MAC.
  - HALT -> RESP with status OK, then HALTED.
  - Any other opcode -> RESP with status ERR.
- ISSUE_x: hold mem_req_valid (or mac_start) and its fields stable until ready is seen. On that cycle go to WAIT_x and clear the timeout counter.
- WAIT_x:
  - done with err = 0 -> RESP, status OK. data = mem_rdata for LOAD, 0 for STORE and MAC.
  - done with err = 1 -> RESP, status ERR, data 0.
- Timeout covers both ISSUE_x and WAIT_x; the counter increments every cycle in those states. When it reaches TIMEOUT_CYCLES-1 without completion:
  - pulse the matching abort for 1 cycle;
  - drop the request;
  - go to RESP with status ERR, data 0xDEAD_0001 truncated to DATA_WIDTH.
  - A done that coincides with the timeout cycle wins over the timeout.
- RESP: resp.valid = 1 for exactly one cycle, carrying status and data. Next state is HALTED if the instruction was HALT, otherwise IDLE.
- Latency: an instruction pushed into an empty FIFO at cycle 0 reaches DECODE at cycle 2. A NOP produces resp.valid at cycle 3. A LOAD whose ready is asserted immediately and whose done arrives at cycle k produces resp.valid at cycle k+1.
- HALTED: the FIFO is flushed on entry. Every newly accepted instruction yields a response the next cycle with status BUSY and data 0. Nothing is dispatched. Exit is by rst only.
- Status encoding: OK = 2'd0, ERR = 2'd1, BUSY = 2'd2. 2'd3 is never produced.
- done or err pulses arriving in states other than WAIT_x are ignored.

Decomposition:
- Add to instr_pkg: resp_status_t enum (RESP_OK, RESP_ERR, RESP_BUSY) and the timeout data constant.
- Keep the sched_state_t enum local to the module.
- One sub-module: nmcu_sync_fifo, parameterised for width and depth, with full, empty and count outputs. It is instantiated for the instruction buffer and is reusable elsewhere.

Test Plan:
- Reset, then NOP pushed at cycle 0 -> resp.valid at cycle 3 with status 0, data 0. instr_ready = 1 throughout; busy deasserts at cycle 4.
- LOAD addr_a = 0x100, len = 4; mem_req_ready held low 5 cycles, then mem_done with mem_rdata = 0xCAFE -> request fields stable while waiting; resp status OK, data 0xCAFE; mem_req_write = 0.
- Five back-to-back STOREs with FIFO_DEPTH = 4 and a stalled memory unit -> instr_ready drops after the FIFO fills; all five responses arrive in order, each status OK.
- MAC with mac_done never asserted, TIMEOUT_CYCLES = 16 -> one mac_abort pulse; resp status ERR, data 0xDEAD0001. The next queued NOP completes normally.
- Opcode 4'h7, then HALT, then LOAD -> ERR response, then an OK response for HALT, halted = 1; the LOAD gets a BUSY response and no mem_req_valid is ever raised.
- rst asserted during WAIT_MAC with 2 entries queued -> next cycle all outputs are at reset values, FIFO is empty, and no resp or abort is emitted.
